// File: rtl/clock_set_ctrl.sv
// Time-setting controller: turns debounced key edges into set-field selection,
// per-field increment pulses (with hold-to-repeat), an idle timeout and a blink enable.
module clock_set_ctrl #(
  parameter int unsigned HOLD_CYCLES    = 100_000_000,
  parameter int unsigned REPEAT_CYCLES  = 20_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
  parameter int unsigned BLINK_CYCLES   = 50_000_000
) (
  input  logic       XTAL_OSC,
  input  logic       rst,
  input  logic       key_flag,
  input  logic       mode_key,
  input  logic       inc_key,
  output logic [1:0] set_state,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       blink
);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    HOUR   = 2'd1,
    MIN    = 2'd2,
    SEC    = 2'd3
  } set_t;

  typedef struct packed {
    logic mode;     // accepted mode press
    logic inc;      // accepted inc press that targets a field
    logic inc_rel;  // inc seen released on a strobe
  } key_ev_t;

  localparam logic [31:0] HOLD_C     = 32'(HOLD_CYCLES);
  localparam logic [31:0] RELOAD_C   = 32'(HOLD_CYCLES - REPEAT_CYCLES);
  localparam logic [31:0] TMO_LAST_C = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] BLK_LAST_C = 32'(BLINK_CYCLES - 1);

  set_t        state, state_nxt;
  logic        mode_last, inc_last;
  logic        rep_arm;
  logic [31:0] hold_cnt, idle_cnt, blink_cnt;

  key_ev_t     kev;
  logic        timeout, state_chg, clr_rep, rep_fire, pulse;

  // Event decode and next state
  always_comb begin
    kev         = '0;
    kev.mode    = key_flag & ~mode_key & mode_last;
    // a simultaneous mode press swallows the inc press
    kev.inc     = key_flag & ~inc_key & inc_last & ~kev.mode & (state != NORMAL);
    kev.inc_rel = key_flag & inc_key;

    timeout = (state != NORMAL) && (idle_cnt == TMO_LAST_C) && !kev.mode && !kev.inc;

    state_nxt = state;
    if (kev.mode) begin
      case (state)
        NORMAL:  state_nxt = HOUR;
        HOUR:    state_nxt = MIN;
        MIN:     state_nxt = SEC;
        default: state_nxt = NORMAL;
      endcase
    end else if (timeout) begin
      state_nxt = NORMAL;
    end

    state_chg = (state_nxt != state);
    clr_rep   = kev.mode | kev.inc_rel | (state_nxt == NORMAL);
    // fire one cycle early so the registered pulse lands when the count hits HOLD
    rep_fire  = rep_arm & ~inc_last & ((hold_cnt + 32'd1) == HOLD_C) & ~clr_rep;
    pulse     = kev.inc | rep_fire;
  end

  always_ff @(posedge XTAL_OSC) begin
    if (!rst) state <= NORMAL;
    else      state <= state_nxt;
  end

  assign set_state = state;

  // Key history and increment pulses
  always_ff @(posedge XTAL_OSC) begin
    if (!rst) begin
      mode_last <= 1'b1;
      inc_last  <= 1'b1;
      inc_hour  <= 1'b0;
      inc_min   <= 1'b0;
      inc_sec   <= 1'b0;
    end else begin
      if (key_flag) begin
        mode_last <= mode_key;
        inc_last  <= inc_key;
      end
      inc_hour <= pulse & (state == HOUR);
      inc_min  <= pulse & (state == MIN);
      inc_sec  <= pulse & (state == SEC);
    end
  end

  // Hold-to-repeat
  always_ff @(posedge XTAL_OSC) begin
    if (!rst) begin
      rep_arm  <= 1'b0;
      hold_cnt <= '0;
    end else if (clr_rep) begin
      rep_arm  <= 1'b0;
      hold_cnt <= '0;
    end else if (kev.inc) begin
      rep_arm  <= 1'b1;
      hold_cnt <= '0;
    end else if (rep_arm && !inc_last) begin
      hold_cnt <= rep_fire ? RELOAD_C : hold_cnt + 32'd1;
    end
  end

  // Inactivity timer; held at zero while repeating
  always_ff @(posedge XTAL_OSC) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (state_nxt == NORMAL || kev.mode || kev.inc || rep_arm) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  // Blink restarts high on every state change
  always_ff @(posedge XTAL_OSC) begin
    if (!rst) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (state_nxt == NORMAL) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (state_chg) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLK_LAST_C) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever the outputs change or pulse.
module tb_clock_set_ctrl;
  localparam int HOLD = 10, REP = 3, TMO = 50, BLK = 4;

  logic       XTAL_OSC = 1'b0;
  logic       rst = 1'b0, key_flag = 1'b0, mode_key = 1'b1, inc_key = 1'b1;
  logic [1:0] set_state;
  logic       inc_hour, inc_min, inc_sec, blink;

  clock_set_ctrl #(
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .TIMEOUT_CYCLES(TMO), .BLINK_CYCLES(BLK)
  ) dut (
    .XTAL_OSC(XTAL_OSC), .rst(rst), .key_flag(key_flag), .mode_key(mode_key),
    .inc_key(inc_key), .set_state(set_state), .inc_hour(inc_hour), .inc_min(inc_min),
    .inc_sec(inc_sec), .blink(blink)
  );

  always #5 XTAL_OSC = ~XTAL_OSC;

  int cyc = 0;
  always @(posedge XTAL_OSC) cyc <= cyc + 1;

  typedef struct { int cyc; logic [1:0] st; logic [2:0] inc; } ev_t;
  typedef struct { int cyc; logic val; } bev_t;
  typedef struct { int cyc; logic [1:0] st; logic [2:0] inc; logic bl; } snap_t;

  ev_t   evq[$];
  bev_t  bq[$];
  snap_t sq[$];

  int   n_chk = 0, n_fail = 0;
  logic mon_en = 1'b0, watch_blink = 1'b0, done = 1'b0;

  // Monitor-private state
  logic [1:0] prev_st = 2'd0;
  logic       prev_blink = 1'b0, prev_watch = 1'b0;
  logic [2:0] iv;
  ev_t        e;
  bev_t       b;
  snap_t      s;

  always @(negedge XTAL_OSC) begin
    iv = {inc_hour, inc_min, inc_sec};
    if (mon_en && (set_state !== prev_st || iv !== 3'b000)) begin
      n_chk++;
      if (evq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got st=%0d inc=%b at cyc %0d, want no event", set_state, iv, cyc);
      end else begin
        e = evq.pop_front();
        if (e.cyc != cyc || e.st !== set_state || e.inc !== iv) begin
          n_fail++;
          $display("FAIL event: got st=%0d inc=%b at cyc %0d, want st=%0d inc=%b at cyc %0d",
                   set_state, iv, cyc, e.st, e.inc, e.cyc);
        end
      end
    end
    if (watch_blink && (blink !== prev_blink || !prev_watch)) begin
      n_chk++;
      if (bq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_blink: got blink=%b at cyc %0d, want no change", blink, cyc);
      end else begin
        b = bq.pop_front();
        if (b.cyc != cyc || b.val !== blink) begin
          n_fail++;
          $display("FAIL blink: got blink=%b at cyc %0d, want blink=%b at cyc %0d", blink, cyc, b.val, b.cyc);
        end
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      s = sq.pop_front();
      n_chk++;
      if (s.st !== set_state || s.inc !== iv || s.bl !== blink) begin
        n_fail++;
        $display("FAIL snapshot cyc %0d: got st=%0d inc=%b blink=%b, want st=%0d inc=%b blink=%b",
                 cyc, set_state, iv, blink, s.st, s.inc, s.bl);
      end
    end
    prev_st    = set_state;
    prev_blink = blink;
    prev_watch = watch_blink;
    if (done || cyc > 20000) begin
      n_chk++;
      if (!done || evq.size() != 0 || bq.size() != 0 || sq.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got done=%b pending ev=%0d blink=%0d snap=%0d, want done=1 and 0 pending",
                 done, evq.size(), bq.size(), sq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  task automatic tick();
    @(posedge XTAL_OSC); #1;
  endtask

  task automatic strobe(input logic m, input logic i);
    key_flag = 1'b1; mode_key = m; inc_key = i;
    tick();
    key_flag = 1'b0;
  endtask

  task automatic push_ev(input int c, input logic [1:0] st, input logic [2:0] inc);
    ev_t x;
    x.cyc = c; x.st = st; x.inc = inc;
    evq.push_back(x);
  endtask

  task automatic push_bl(input int c, input logic v);
    bev_t x;
    x.cyc = c; x.val = v;
    bq.push_back(x);
  endtask

  task automatic push_snap(input int c);
    snap_t x;
    x.cyc = c; x.st = 2'd0; x.inc = 3'b000; x.bl = 1'b0;
    sq.push_back(x);
  endtask

  // Mode press + release; expects set_state = st one cycle after the press strobe
  task automatic press_mode(input logic [1:0] st);
    push_ev(cyc + 1, st, 3'b000);
    strobe(1'b0, 1'b1);
    repeat (2) tick();
    strobe(1'b1, 1'b1);
    repeat (2) tick();
  endtask

  int t0;
  initial begin
    // Reset
    push_snap(2);
    repeat (3) tick();
    rst = 1'b1;
    mon_en = 1'b1;
    tick();

    // Mode cycles NORMAL->HOUR->MIN->SEC->NORMAL
    for (int k = 1; k <= 4; k++) press_mode(2'(k % 4));

    // Hold-to-repeat in MIN: press at t0, release at t0+30
    press_mode(2'd1);
    press_mode(2'd2);
    t0 = cyc;
    push_ev(t0 + 1, 2'd2, 3'b010);
    for (int k = 11; k <= 29; k += 3) push_ev(t0 + k, 2'd2, 3'b010);
    strobe(1'b1, 1'b0);
    while (cyc < t0 + 30) tick();
    strobe(1'b1, 1'b1);
    repeat (3) tick();
    press_mode(2'd3);
    press_mode(2'd0);

    // Inc in NORMAL is ignored
    strobe(1'b1, 1'b0);
    repeat (2) tick();
    strobe(1'b1, 1'b1);
    repeat (2) tick();

    // Simultaneous mode+inc in HOUR: advance only
    press_mode(2'd1);
    push_ev(cyc + 1, 2'd2, 3'b000);
    strobe(1'b0, 1'b0);
    repeat (2) tick();
    strobe(1'b1, 1'b1);
    repeat (2) tick();

    // SEC idle: timeout 50 cycles after entry, blink period 2*4
    t0 = cyc + 1;
    push_ev(t0, 2'd3, 3'b000);
    push_ev(t0 + TMO, 2'd0, 3'b000);
    for (int m = 0; m <= 12; m++) push_bl(t0 + 4 * m, (m % 2) == 0);
    push_bl(t0 + TMO, 1'b0);
    strobe(1'b0, 1'b1);
    watch_blink = 1'b1;
    tick();
    strobe(1'b1, 1'b1);
    while (cyc < t0 + TMO + 1) tick();
    watch_blink = 1'b0;

    // Reset during an inc hold in HOUR
    press_mode(2'd1);
    t0 = cyc;
    push_ev(t0 + 1, 2'd1, 3'b100);
    push_ev(t0 + 11, 2'd1, 3'b100);
    push_ev(t0 + 13, 2'd0, 3'b000);
    push_snap(t0 + 13);
    push_snap(t0 + 14);
    strobe(1'b1, 1'b0);
    while (cyc < t0 + 12) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    strobe(1'b1, 1'b0);
    repeat (2) tick();
    strobe(1'b1, 1'b1);
    repeat (2) tick();

    // mode_key low without key_flag, then repeated strobe with mode_last=0
    mode_key = 1'b0;
    repeat (20) tick();
    mode_key = 1'b1;
    tick();
    t0 = cyc;
    push_ev(t0 + 1, 2'd1, 3'b000);
    push_ev(t0 + 1 + TMO, 2'd0, 3'b000);
    strobe(1'b0, 1'b1);
    repeat (3) tick();
    strobe(1'b0, 1'b1);
    repeat (3) tick();
    strobe(1'b1, 1'b1);
    while (cyc < t0 + 60) tick();
    done = 1'b1;
  end
endmodule
